paint_writer: RTL
=================

# paint_writer

Read-modify-write stage that paints tracked-pen points into the SRAM frame bitmap (640x480, 1 bit per pixel, 16 pixels per 16-bit word, 40 words per line). Sits beside `pixel_buffer` on the shared SRAM controller:
- it accepts (x, y) points from the camera/tracker through a 4-entry FIFO;
- it performs all SRAM accesses only during vertical blank, while `pixel_buffer` is idle;
- each paint reads the target word, ORs in the pixel bit and writes the word back.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: point FIFO entries (power of two, 2..16).
- `WIN_FIRST`, 482: first `vcounter` line on which SRAM access may start.
- `WIN_LAST`, 523: last `vcounter` line on which a new paint may start.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low; 0 = reset.
- `pt_valid`  in  1  point offered.
- `pt_ready`  out  1  FIFO not full; transfer when `pt_valid && pt_ready`.
- `pt_x`  in  10  pixel column.
- `pt_y`  in  10  pixel row.
- `hcounter`  in  11  VGA horizontal counter.
- `vcounter`  in  10  VGA vertical counter.
- `pb_state`  in  4  `ram_state` of `pixel_buffer`; 0 = idle.
- `ready`  in  1  SRAM controller ready.
- `address`  out  18  SRAM word address.
- `data_read`  in  16  SRAM read data.
- `data_write`  out  16  SRAM write data.
- `read`  out  1  read strobe.
- `write`  out  1  write strobe.
- `bus_own`  out  1  high while this block drives the SRAM bus; the top level muxes `address`/`data_write`/`read`/`write` on it.
- `paint_count`  out  16  paints completed; wraps at 65535 -> 0.
- `drop_count`  out  8  out-of-range points dropped; saturates at 255.

## Operation
Point intake:
- A point is accepted on the handshake.
- If `pt_x >= 640` or `pt_y >= 480`, the point is not queued and `drop_count` increments.
- Otherwise the point is pushed into the FIFO.
- `pt_ready` = FIFO not full; it is independent of `pt_valid`.
- A push and a pop in the same cycle are both honoured.

Address and mask:
- word address = `pt_y*40 + pt_x[9:4]`, computed as 18-bit: `(y<<5)+(y<<3)+x[9:4]`. No multiplier or divider.
- bit mask = `16'h8000 >> pt_x[3:0]`, so pixel 0 of each word is the MSB.

Window:
- `win_open` = (`WIN_FIRST <= vcounter <= WIN_LAST`) && `pb_state == 0`.
- A paint starts only when `win_open` is true and the FIFO is non-empty.
- A paint already started always completes, even if the window closes.

State machine (4-bit state):
- IDLE: `bus_own=0`, `read=0`, `write=0`. If `win_open` and the FIFO is non-empty, latch the FIFO head into working x/y, go to RD_REQ.
- RD_REQ: `bus_own=1`. When `ready`: drive `address`, go to RD_WAIT.
- RD_WAIT: `read<=1`, go to RD_CAP.
- RD_CAP: `read<=0`; latch `data_read` into `word`, go to WR_REQ.
- WR_REQ: when `ready`: `data_write <= word | mask`, go to WR_PULSE. `address` is held.
- WR_PULSE: `write<=1`, go to WR_DONE.
- WR_DONE: `write<=0`. If a further brush row is pending (config only), step y and go to RD_REQ. Otherwise pop the FIFO, increment `paint_count`, go to IDLE.

Read-modify-write skip:
- If `(word & mask) == mask`, WR_REQ and WR_PULSE are skipped and the state goes straight to WR_DONE.
- No SRAM write is issued, and the paint is still counted.

Reset (`reset==0` at a clock edge):
- state IDLE, FIFO emptied.
- `pt_ready=0` during reset, 1 on the first cycle after.
- `bus_own=0`, `read=0`, `write=0`, `address=0`, `data_write=0`, `paint_count=0`, `drop_count=0`.
- Reset mid-paint abandons the paint immediately; the SRAM word may be left unwritten.

## Timing
- Minimum paint: 6 cycles from IDLE exit to IDLE re-entry with `ready` constantly high; 4 cycles when the write is skipped.
- Each wait cycle with `ready` low in RD_REQ or WR_REQ adds one cycle.
- `read` and `write` are each exactly 1-cycle pulses. The corresponding `address` is stable from the cycle before the pulse until WR_DONE.
- Latency from point accept to SRAM write: unbounded; up to one frame when the point arrives during active video.
- `bus_own` rises in the RD_REQ entry cycle and falls in the cycle IDLE is re-entered.

## Configuration
- `PAINT_BRUSH2_EN` defined: each point paints a 2x2 block.
  - Mask also sets bit x+1 when `x[3:0] != 15`; the block is clipped at the word edge.
  - A second read-modify-write covers row y+1 when `y < 479`.
  - `paint_count` increments once per point.
- Undefined: single-pixel paint; no second row logic is built.

## Test plan
- Reset low 3 cycles with `pt_valid=1` -> `pt_ready=0`, no pushes, all outputs 0; `pt_ready=1` on the first cycle after release.
- Point (17,2), word 81 initially `16'h0001`, window open, `ready=1` -> `address=81`, one `read` pulse, one `write` with `data_write=16'h4001`, 6-cycle paint, `paint_count=1`.
- Same point pushed again -> read only, no `write` pulse, `paint_count=2`.
- 5 points pushed during `vcounter=100` -> `pt_ready` low after 4; no `bus_own` until `vcounter=482` with `pb_state=0`; 4 paints in FIFO order.
- `pb_state=8` at `vcounter=482` -> no access until `pb_state=0`. Point (700,10) -> dropped, `drop_count=1`.
- With `PAINT_BRUSH2_EN`, point (15,0) -> word 0 gets mask `16'h0001`, word 40 gets mask `16'h0001`; point (0,479) -> one row only, mask `16'hC000`.

Source files
------------

// File: rtl/paint_writer.sv
// paint_writer: queues tracked-pen points and paints them into the 1bpp SRAM
// frame bitmap with read-modify-write cycles issued only during vertical blank.
// Optional feature macro: PAINT_BRUSH2_EN (2x2 brush, second row per point).
module paint_writer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WIN_FIRST  = 482,
    parameter int unsigned WIN_LAST   = 523
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pt_valid,
    output logic        pt_ready,
    input  logic [9:0]  pt_x,
    input  logic [9:0]  pt_y,
    input  logic [10:0] hcounter,
    input  logic [9:0]  vcounter,
    input  logic [3:0]  pb_state,
    input  logic        ready,
    output logic [17:0] address,
    input  logic [15:0] data_read,
    output logic [15:0] data_write,
    output logic        read,
    output logic        write,
    output logic        bus_own,
    output logic [15:0] paint_count,
    output logic [7:0]  drop_count
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [9:0]    WIN_FIRST_V = 10'(WIN_FIRST);
    localparam logic [9:0]    WIN_LAST_V  = 10'(WIN_LAST);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RD_REQ   = 4'd1,
        S_RD_WAIT  = 4'd2,
        S_RD_CAP   = 4'd3,
        S_WR_REQ   = 4'd4,
        S_WR_PULSE = 4'd5,
        S_WR_DONE  = 4'd6
    } state_t;

    state_t         state;
    logic [9:0]     fifo_x [FIFO_DEPTH];
    logic [9:0]     fifo_y [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic [9:0]     wx;
    logic [9:0]     wy;
    logic [15:0]    word;
    logic [15:0]    mask_c;
    logic [17:0]    addr_c;
    logic           in_range;
    logic           accept;
    logic           push;
    logic           pop;
    logic           win_open;
    logic           row_pending;
    logic           unused_ok;

`ifdef PAINT_BRUSH2_EN
    logic           second_row;
`endif

    assign unused_ok = ^hcounter;

    // Intake decode, paint window, working-point address and mask
    always_comb begin
        in_range = (pt_x < 10'd640) && (pt_y < 10'd480);
        accept   = pt_valid && pt_ready;
        push     = accept && in_range;
        win_open = (vcounter >= WIN_FIRST_V) && (vcounter <= WIN_LAST_V) && (pb_state == 4'd0);
        addr_c   = (18'(wy) << 5) + (18'(wy) << 3) + 18'(wx[9:4]);
        mask_c   = 16'h8000 >> wx[3:0];
`ifdef PAINT_BRUSH2_EN
        // Neighbour pixel x+1; shifts out to nothing when x is the word's last pixel
        mask_c      = mask_c | (mask_c >> 1);
        row_pending = !second_row && (wy < 10'd479);
`else
        row_pending = 1'b0;
`endif
        pop        = (state == S_WR_DONE) && !row_pending;
        count_next = count + CW'(push) - CW'(pop);
    end

    // Point FIFO storage (contents need no reset; pointers guard validity)
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_x[wr_ptr] <= pt_x;
            fifo_y[wr_ptr] <= pt_y;
        end
    end

    // FIFO control, counters and the read-modify-write state machine
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pt_ready    <= 1'b0;
            wx          <= '0;
            wy          <= '0;
            word        <= '0;
            bus_own     <= 1'b0;
            read        <= 1'b0;
            write       <= 1'b0;
            address     <= '0;
            data_write  <= '0;
            paint_count <= '0;
            drop_count  <= '0;
`ifdef PAINT_BRUSH2_EN
            second_row  <= 1'b0;
`endif
        end else begin
            count    <= count_next;
            pt_ready <= (count_next != DEPTH_C);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (accept && !in_range && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;

            case (state)
                S_IDLE: begin
                    if (win_open && count != '0) begin
                        wx      <= fifo_x[rd_ptr];
                        wy      <= fifo_y[rd_ptr];
                        bus_own <= 1'b1;
`ifdef PAINT_BRUSH2_EN
                        second_row <= 1'b0;
`endif
                        state   <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (ready) begin
                        address <= addr_c;
                        state   <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    read  <= 1'b1;
                    state <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    read <= 1'b0;
                    word <= data_read;
                    // Pixel(s) already set: skip the write entirely
                    if ((data_read & mask_c) == mask_c) state <= S_WR_DONE;
                    else                                state <= S_WR_REQ;
                end
                S_WR_REQ: begin
                    if (ready) begin
                        data_write <= word | mask_c;
                        state      <= S_WR_PULSE;
                    end
                end
                S_WR_PULSE: begin
                    write <= 1'b1;
                    state <= S_WR_DONE;
                end
                S_WR_DONE: begin
                    write <= 1'b0;
                    if (row_pending) begin
                        wy    <= wy + 10'd1;
`ifdef PAINT_BRUSH2_EN
                        second_row <= 1'b1;
`endif
                        state <= S_RD_REQ;
                    end else begin
                        paint_count <= paint_count + 16'd1;
                        bus_own     <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    bus_own <= 1'b0;
                    read    <= 1'b0;
                    write   <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
